display_scan_controller: RTL

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 34 +++
 rtl/seven_seg_decoder.sv | 11 +
 rtl/display_scan_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; packed so entry 0 is the rightmost literal.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex-to-seven-segment decode, active-low outputs.
module seven_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[digit];

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit scanner: each slot blanks the anodes briefly, then
// lights the selected digit; segments follow the downstream mux with one cycle of latency.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic [3:0]            time_digit,
    input  logic                  dp_in,
    output logic [NUM_DIGITS-1:0] selector,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);
    localparam cnt_t SLOT_LAST  = cnt_t'(REFRESH_DIV - 1);

    scan_state_t           state, state_next;
    cnt_t                  cnt, cnt_next;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            seg_dec;

    seven_seg_decoder u_decoder (
        .digit (time_digit),
        .seg_n (seg_dec)
    );

    // The counter runs across the whole slot; BLANK owns the first
    // BLANK_CYCLES counts and SHOW the remainder, so slot length is fixed.
    always_comb begin
        // NOTE: every output of this block is given a default first so that
        // no path leaves a variable unassigned, which would infer a latch.
        state_next = state;
        cnt_next   = cnt;
        sel_next   = selector;

        unique case (state)
            IDLE: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
            BLANK: begin
                cnt_next = cnt + cnt_t'(1);
                if (cnt == BLANK_LAST) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (cnt == SLOT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    sel_next   = {selector[NUM_DIGITS-2:0], selector[NUM_DIGITS-1]};
                end else begin
                    cnt_next = cnt + cnt_t'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Dropping enable parks the scan on the current digit, from any state.
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            sel_next   = selector;
        end

        // Anodes are registered from the next state so they change with it, glitch-free.
        anode_next = (state_next == SHOW) ? ~(sel_next & digit_mask) : '1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            selector <= NUM_DIGITS'(1);
            anode_n  <= '1;
            seg_n    <= SEG_BLANK;
            dp_n     <= 1'b1;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            selector <= sel_next;
            anode_n  <= anode_next;
            seg_n    <= seg_dec;
            dp_n     <= ~dp_in;
        end
    end

endmodule
